// File: rtl/wb_ibex_bus_arbiter.sv
// wb_ibex_bus_arbiter: round-robin merge of Ibex instr/data Wishbone B4 pipelined masters onto one slave bus,
// with per-grant outstanding tracking and a watchdog that aborts a hung transfer with err.
module wb_ibex_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_instr_addr,
    input  logic        i_instr_cyc,
    input  logic        i_instr_stb,
    input  logic        i_instr_we,
    input  logic [3:0]  i_instr_sel,
    input  logic [31:0] i_instr_data,
    output logic        o_instr_wb_ack,
    output logic        o_instr_wb_err,
    output logic        o_instr_wb_stall,
    output logic [31:0] o_instr_wb_data,
    input  logic [31:0] i_data_addr,
    input  logic        i_data_cyc,
    input  logic        i_data_stb,
    input  logic        i_data_we,
    input  logic [3:0]  i_data_sel,
    input  logic [31:0] i_data_data,
    output logic        o_data_wb_ack,
    output logic        o_data_wb_err,
    output logic        o_data_wb_stall,
    output logic [31:0] o_data_wb_data,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic        o_timeout
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;
    state_t r_state, w_state_n;
    logic r_last, w_last_n, r_owner, w_owner_n, r_first, w_first_n;
    logic [OW-1:0] r_outst, w_outst_n;
    logic [TW-1:0] r_timer, w_timer_n;
    logic w_gnt, w_own_cyc, w_own_stb, w_full, w_acc, w_done, w_abort;
    // r_owner/r_last: 1 = data master, 0 = instr master
    assign w_gnt     = (r_state == GNT_I) || (r_state == GNT_D);
    assign w_abort   = r_state == ABORT;
    assign w_own_cyc = r_owner ? i_data_cyc : i_instr_cyc;
    assign w_own_stb = r_owner ? i_data_stb : i_instr_stb;
    assign w_full    = r_outst == OW'(MAX_OUTSTANDING);
    assign w_done    = w_gnt & (i_wb_ack | i_wb_err);
    assign o_wb_cyc  = w_gnt & w_own_cyc;
    assign o_wb_stb  = o_wb_cyc & w_own_stb & !w_full;
    assign o_wb_addr = r_owner ? i_data_addr : i_instr_addr;
    assign o_wb_we   = r_owner ? i_data_we : i_instr_we;
    assign o_wb_sel  = r_owner ? i_data_sel : i_instr_sel;
    assign o_wb_data = r_owner ? i_data_data : i_instr_data;
    assign w_acc     = o_wb_stb & !i_wb_stall;
    assign o_instr_wb_stall = !(w_gnt & !r_owner) | i_wb_stall | w_full;
    assign o_data_wb_stall  = !(w_gnt & r_owner) | i_wb_stall | w_full;
    assign o_instr_wb_ack   = w_gnt & !r_owner & i_wb_ack;
    assign o_data_wb_ack    = w_gnt & r_owner & i_wb_ack;
    assign o_instr_wb_err   = (w_gnt & !r_owner & i_wb_err) | (w_abort & !r_owner & r_first);
    assign o_data_wb_err    = (w_gnt & r_owner & i_wb_err) | (w_abort & r_owner & r_first);
    assign o_timeout        = w_abort & r_first;
    assign o_instr_wb_data  = i_wb_data;
    assign o_data_wb_data   = i_wb_data;
    always_comb begin
        w_state_n = r_state;
        w_last_n  = r_last;
        w_owner_n = r_owner;
        w_outst_n = r_outst;
        w_timer_n = r_timer;
        w_first_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_instr_cyc || i_data_cyc) begin
                    w_owner_n = i_data_cyc & (!i_instr_cyc | !r_last);
                    w_state_n = w_owner_n ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (!w_own_cyc) begin
                    w_state_n = IDLE;
                    w_last_n  = r_owner;
                    w_outst_n = '0;
                    w_timer_n = '0;
                end else begin
                    w_outst_n = (w_acc && !w_done) ? r_outst + OW'(1) :
                                (w_done && !w_acc && r_outst != '0) ? r_outst - OW'(1) : r_outst;
                    if (r_outst == '0 || w_done) begin
                        w_timer_n = '0;
                    end else if (TIMEOUT_CYCLES != 0 && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        w_state_n = ABORT;
                        w_first_n = 1'b1;
                        w_outst_n = '0;
                        w_timer_n = '0;
                    end else begin
                        w_timer_n = r_timer + TW'(1);
                    end
                end
            end
            ABORT: begin
                if (!w_own_cyc) begin
                    w_state_n = IDLE;
                    w_last_n  = r_owner;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
            r_owner <= 1'b0;
            r_first <= 1'b0;
            r_outst <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_n;
            r_last  <= w_last_n;
            r_owner <= w_owner_n;
            r_first <= w_first_n;
            r_outst <= w_outst_n;
            r_timer <= w_timer_n;
        end
    end
endmodule

// File: tb/tb_wb_ibex_bus_arbiter.sv
// tb_wb_ibex_bus_arbiter: directed stimulus with an expected-response queue drained by a monitor
// that checks every ack/err seen by either master.
module tb_wb_ibex_bus_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] i_instr_addr = '0, i_instr_data = '0, i_data_addr = '0, i_data_data = '0, i_wb_data = '0;
    logic i_instr_cyc = 0, i_instr_stb = 0, i_instr_we = 0, i_data_cyc = 0, i_data_stb = 0, i_data_we = 0;
    logic [3:0] i_instr_sel = '0, i_data_sel = '0, o_wb_sel;
    logic i_wb_ack = 0, i_wb_err = 0, i_wb_stall = 0;
    logic o_instr_wb_ack, o_instr_wb_err, o_instr_wb_stall, o_data_wb_ack, o_data_wb_err, o_data_wb_stall;
    logic [31:0] o_instr_wb_data, o_data_wb_data, o_wb_addr, o_wb_data;
    logic o_wb_cyc, o_wb_stb, o_wb_we, o_timeout;
    int vectors = 0, miscompares = 0;
    typedef struct {logic [3:0] f; logic [31:0] d;} exp_t;
    exp_t q[$];
    exp_t e_mon;
    logic [3:0] f_mon;
    always #5 clk = ~clk;
    wb_ibex_bus_arbiter #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_instr_addr(i_instr_addr), .i_instr_cyc(i_instr_cyc), .i_instr_stb(i_instr_stb),
        .i_instr_we(i_instr_we), .i_instr_sel(i_instr_sel), .i_instr_data(i_instr_data),
        .o_instr_wb_ack(o_instr_wb_ack), .o_instr_wb_err(o_instr_wb_err),
        .o_instr_wb_stall(o_instr_wb_stall), .o_instr_wb_data(o_instr_wb_data),
        .i_data_addr(i_data_addr), .i_data_cyc(i_data_cyc), .i_data_stb(i_data_stb),
        .i_data_we(i_data_we), .i_data_sel(i_data_sel), .i_data_data(i_data_data),
        .o_data_wb_ack(o_data_wb_ack), .o_data_wb_err(o_data_wb_err),
        .o_data_wb_stall(o_data_wb_stall), .o_data_wb_data(o_data_wb_data),
        .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_sel(o_wb_sel), .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
        .o_timeout(o_timeout)
    );
    // flags are {instr_ack, instr_err, data_ack, data_err}
    always @(negedge clk) begin
        f_mon = {o_instr_wb_ack, o_instr_wb_err, o_data_wb_ack, o_data_wb_err};
        if (!rst && f_mon != 4'b0) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected act=%b req=none", f_mon);
            end else begin
                e_mon = q.pop_front();
                if (f_mon != e_mon.f || (f_mon[3] && o_instr_wb_data != e_mon.d) ||
                    (f_mon[1] && o_data_wb_data != e_mon.d)) begin
                    miscompares++;
                    $display("FAIL resp act=%b/%h req=%b/%h", f_mon,
                             f_mon[3] ? o_instr_wb_data : o_data_wb_data, e_mon.f, e_mon.d);
                end
            end
        end
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s act=%h req=%h", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic smp();
        @(negedge clk);
    endtask
    task automatic push(input logic [3:0] f, input logic [31:0] d);
        exp_t e;
        e.f = f;
        e.d = d;
        q.push_back(e);
    endtask
    task automatic chk_reset_outs(input string n);
        chk({n, "_cyc"}, 32'(o_wb_cyc), 0);
        chk({n, "_stb"}, 32'(o_wb_stb), 0);
        chk({n, "_stalls"}, {30'd0, o_instr_wb_stall, o_data_wb_stall}, 3);
        chk({n, "_ackerr"}, {28'd0, o_instr_wb_ack, o_instr_wb_err, o_data_wb_ack, o_data_wb_err}, 0);
        chk({n, "_timeout"}, 32'(o_timeout), 0);
    endtask
    initial begin
        #12;
        chk_reset_outs("reset");
        tick();
        rst = 1'b0;
        // tie after reset: data wins, instr granted after data releases
        i_instr_cyc = 1; i_data_cyc = 1;
        smp(); chk("tie_idle_cyc", 32'(o_wb_cyc), 0); tick();
        smp();
        chk("tie_data_stall", 32'(o_data_wb_stall), 0);
        chk("tie_instr_stall", 32'(o_instr_wb_stall), 1);
        chk("tie_cyc", 32'(o_wb_cyc), 1);
        tick();
        i_data_cyc = 0;
        smp(); chk("rel_cyc_same", 32'(o_wb_cyc), 0); tick();
        smp(); chk("idle_instr_stall", 32'(o_instr_wb_stall), 1); tick();
        smp(); chk("instr_gnt_stall", 32'(o_instr_wb_stall), 0); tick();
        // instr 6 pipelined strobes, slave silent: 4 accepted
        i_instr_stb = 1; i_instr_addr = 32'h40;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk($sformatf("pipe_stall%0d", k), 32'(o_instr_wb_stall), k >= 4 ? 1 : 0);
            chk($sformatf("pipe_stb%0d", k), 32'(o_wb_stb), k >= 4 ? 0 : 1);
            tick();
        end
        i_instr_stb = 0; i_instr_cyc = 0;
        smp(); chk("pipe_rel_cyc", 32'(o_wb_cyc), 0); tick();
        i_wb_ack = 1;
        smp(); chk("late_ack_drop", 32'(o_instr_wb_ack), 0); tick();
        i_wb_ack = 0;
        // outstanding accounting: accept+ack keeps count, drain, spurious ack, refill
        i_instr_cyc = 1;
        smp(); tick();
        i_instr_stb = 1;
        smp(); chk("cnt_c1", 32'(o_instr_wb_stall), 0); tick();
        smp(); tick();
        i_wb_ack = 1; i_wb_data = 32'hA0A0_0001; push(4'b1000, 32'hA0A0_0001);
        smp(); chk("cnt_same", 32'(o_instr_wb_stall), 0); tick();
        i_wb_ack = 0;
        smp(); chk("cnt_c4", 32'(o_instr_wb_stall), 0); tick();
        smp(); chk("cnt_c5", 32'(o_instr_wb_stall), 0); tick();
        smp(); chk("cnt_full", 32'(o_instr_wb_stall), 1); chk("cnt_full_stb", 32'(o_wb_stb), 0); tick();
        i_instr_stb = 0;
        for (int k = 0; k < 5; k++) begin
            i_wb_ack = 1; i_wb_data = 32'hB000_0000 + 32'(k); push(4'b1000, 32'hB000_0000 + 32'(k));
            smp(); tick();
        end
        i_wb_ack = 0; i_instr_stb = 1;
        for (int k = 0; k < 5; k++) begin
            smp(); chk($sformatf("refill%0d", k), 32'(o_instr_wb_stall), k == 4 ? 1 : 0); tick();
        end
        i_instr_stb = 0; i_instr_cyc = 0;
        smp(); chk("refill_rel", 32'(o_wb_cyc), 0); tick();
        // data read at 0x100, acked two cycles after accept
        i_data_cyc = 1; i_data_stb = 1; i_data_addr = 32'h100; i_data_sel = 4'hF;
        smp(); chk("rd_idle_stall", 32'(o_data_wb_stall), 1); tick();
        smp();
        chk("rd_cyc", 32'(o_wb_cyc), 1);
        chk("rd_stb", 32'(o_wb_stb), 1);
        chk("rd_addr", o_wb_addr, 32'h100);
        chk("rd_sel", 32'(o_wb_sel), 32'hF);
        chk("rd_we", 32'(o_wb_we), 0);
        chk("rd_stall", 32'(o_data_wb_stall), 0);
        tick();
        i_data_stb = 0;
        smp(); tick();
        i_wb_ack = 1; i_wb_data = 32'hCAFE_0100; push(4'b0010, 32'hCAFE_0100);
        smp(); tick();
        i_wb_ack = 0; i_data_cyc = 0;
        smp(); chk("rd_rel_cyc", 32'(o_wb_cyc), 0); tick();
        // watchdog: one accepted data request never acked
        i_data_cyc = 1; i_data_stb = 1;
        smp(); tick();
        smp(); chk("wd_accept", 32'(o_data_wb_stall), 0); tick();
        i_data_stb = 0;
        push(4'b0001, 32'h0);
        for (int k = 2; k < 12; k++) begin
            smp();
            chk($sformatf("wd_to%0d", k), 32'(o_timeout), k == 10 ? 1 : 0);
            chk($sformatf("wd_cyc%0d", k), 32'(o_wb_cyc), k < 10 ? 1 : 0);
            if (k == 11) chk("wd_abort_stall", 32'(o_data_wb_stall), 1);
            tick();
        end
        i_data_cyc = 0;
        smp(); tick();
        // reset mid-transfer with 3 outstanding
        i_instr_cyc = 1;
        smp(); tick();
        i_instr_stb = 1;
        for (int k = 0; k < 3; k++) begin
            smp(); tick();
        end
        i_instr_stb = 0;
        smp(); chk("rst_pre_cyc", 32'(o_wb_cyc), 1); tick();
        rst = 1'b1;
        #2;
        chk_reset_outs("midrst");
        tick();
        rst = 1'b0; i_data_cyc = 1;
        smp(); tick();
        smp();
        chk("rearb_data", 32'(o_data_wb_stall), 0);
        chk("rearb_instr", 32'(o_instr_wb_stall), 1);
        tick();
        i_instr_cyc = 0; i_data_cyc = 0;
        smp(); tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
